rf_access_ctrl: RTL and testbench

// - Initiator side of the register-file bitline interface: turns 4-bit register indices into one-hot

---
 rtl/rf_pkg.sv | 18 +
 rtl/rf_onehot_decoder.sv | 21 ++
 rtl/rf_access_ctrl.sv | 156 +++++++++++++++
 tb/tb_rf_access_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants for the register-file access controller.
// Holds the register-file geometry, the controller FSM state encoding and
// the index of the hardwired-zero register R0.
package rf_pkg;

    localparam int NUM_REGS = 16;   // registers in the file, one strobe bit each
    localparam int DATA_W   = 16;   // register / bitline width
    localparam int IDX_W    = 4;    // log2(NUM_REGS)

    // Controller FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // R0 reads as zero and is never written
    localparam logic [IDX_W-1:0] R0_IDX = '0;

endpackage

// File: rtl/rf_onehot_decoder.sv
// One-hot decoder for register-file strobes.
// Ports:
//   idx    in  IDX_W     register index
//   en     in  1         gates the whole output
//   onehot out NUM_REGS  bit idx set when en, all zero for idx == R0
module rf_onehot_decoder
    import rf_pkg::*;
(
    input  logic [IDX_W-1:0]    idx,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    // R0 never gets a strobe: it has no cell behind it.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
            assign onehot[gi] = en && (idx == IDX_W'(gi)) && (IDX_W'(gi) != R0_IDX);
        end
    endgenerate

endmodule

// File: rtl/rf_access_ctrl.sv
// Initiator side of the register-file bitline interface.
// Turns register indices into one-hot WriteReg / ReadEnable strobes, drives
// write data, samples both bitline buses and returns two read operands over
// a valid/ready handshake.
//
// Build option: define RF_ACCESS_BYPASS_EN to capture a same-cycle write
// instead of the bitline (write-before-read). Undefined, the bitline value
// is always captured (read-before-write).
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready      read request handshake, req_src1/req_src2 indices
//   rsp_valid/rsp_ready      response handshake, rsp_data1/rsp_data2 operands
//   wr_en, wr_reg, wr_data   single-cycle write request
//   rf_D, rf_WriteReg        register-file write data and one-hot write strobe
//   rf_ReadEnable1/2         one-hot bitline read selects (only during DRIVE)
//   rf_Bitline1/2            bitline buses, sampled at the end of DRIVE
module rf_access_ctrl
    import rf_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [IDX_W-1:0]    req_src1,
    input  logic [IDX_W-1:0]    req_src2,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data1,
    output logic [DATA_W-1:0]   rsp_data2,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_reg,
    input  logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W-1:0]   rf_D,
    output logic [NUM_REGS-1:0] rf_WriteReg,
    output logic [NUM_REGS-1:0] rf_ReadEnable1,
    output logic [NUM_REGS-1:0] rf_ReadEnable2,
    input  logic [DATA_W-1:0]   rf_Bitline1,
    input  logic [DATA_W-1:0]   rf_Bitline2
);

    logic [1:0]        state_reg, state_next;
    logic [IDX_W-1:0]  src1_reg, src1_next;
    logic [IDX_W-1:0]  src2_reg, src2_next;
    logic [DATA_W-1:0] data1_reg, data1_next;
    logic [DATA_W-1:0] data2_reg, data2_next;
    logic              rsp_valid_reg, rsp_valid_next;

    logic              drive;
    logic [DATA_W-1:0] cap1, cap2;

    assign drive     = (state_reg == ST_DRIVE);
    // In HOLD a new request can only be taken when the response leaves.
    assign req_ready = (state_reg == ST_IDLE) || ((state_reg == ST_HOLD) && rsp_ready);

    assign rsp_valid = rsp_valid_reg;
    assign rsp_data1 = data1_reg;
    assign rsp_data2 = data2_reg;

    // Write port is purely combinational and independent of the FSM.
    assign rf_D = wr_data;

    rf_onehot_decoder u_dec_wr (
        .idx    (wr_reg),
        .en     (wr_en),
        .onehot (rf_WriteReg)
    );

    // Read enables come from registered state only, so they drop as soon as
    // reset asserts and the bitlines float outside DRIVE.
    rf_onehot_decoder u_dec_rd1 (
        .idx    (src1_reg),
        .en     (drive),
        .onehot (rf_ReadEnable1)
    );

    rf_onehot_decoder u_dec_rd2 (
        .idx    (src2_reg),
        .en     (drive),
        .onehot (rf_ReadEnable2)
    );

    // Operand capture. R0 has no enable, so its bitline floats: force zero.
    always_comb begin
        cap1 = (src1_reg == R0_IDX) ? '0 : rf_Bitline1;
        cap2 = (src2_reg == R0_IDX) ? '0 : rf_Bitline2;
`ifdef RF_ACCESS_BYPASS_EN
        if (wr_en && (wr_reg == src1_reg) && (src1_reg != R0_IDX)) begin
            cap1 = wr_data;
        end
        if (wr_en && (wr_reg == src2_reg) && (src2_reg != R0_IDX)) begin
            cap2 = wr_data;
        end
`endif
    end

    always_comb begin
        state_next     = state_reg;
        src1_next      = src1_reg;
        src2_next      = src2_reg;
        data1_next     = data1_reg;
        data2_next     = data2_reg;
        rsp_valid_next = rsp_valid_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    src1_next  = req_src1;
                    src2_next  = req_src2;
                    state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                data1_next     = cap1;
                data2_next     = cap2;
                rsp_valid_next = 1'b1;
                state_next     = ST_HOLD;
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    if (req_valid) begin
                        // back-to-back: skip IDLE
                        src1_next  = req_src1;
                        src2_next  = req_src2;
                        state_next = ST_DRIVE;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                rsp_valid_next = 1'b0;
                state_next     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            src1_reg      <= '0;
            src2_reg      <= '0;
            data1_reg     <= '0;
            data2_reg     <= '0;
            rsp_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            src1_reg      <= src1_next;
            src2_reg      <= src2_next;
            data1_reg     <= data1_next;
            data2_reg     <= data2_next;
            rsp_valid_reg <= rsp_valid_next;
        end
    end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Testbench for rf_access_ctrl: a behavioural bitcell array drives the
// bitlines; expected operands come from a plain reference array updated
// by the bench on every write it issues.
module tb_rf_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_src1, req_src2;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data1, rsp_data2;
    logic        wr_en;
    logic [3:0]  wr_reg;
    logic [15:0] wr_data;
    logic [15:0] rf_D;
    logic [15:0] rf_WriteReg, rf_ReadEnable1, rf_ReadEnable2;
    logic [15:0] rf_Bitline1, rf_Bitline2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] ref_rf [16];   // expected register contents
    logic [15:0] cells  [16];   // bitcell array seen by the DUT

    always #5 clk = ~clk;

    rf_access_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_src1       (req_src1),
        .req_src2       (req_src2),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data1      (rsp_data1),
        .rsp_data2      (rsp_data2),
        .wr_en          (wr_en),
        .wr_reg         (wr_reg),
        .wr_data        (wr_data),
        .rf_D           (rf_D),
        .rf_WriteReg    (rf_WriteReg),
        .rf_ReadEnable1 (rf_ReadEnable1),
        .rf_ReadEnable2 (rf_ReadEnable2),
        .rf_Bitline1    (rf_Bitline1),
        .rf_Bitline2    (rf_Bitline2)
    );

    // Bitcell array: cells update on the edge where their strobe is high.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) cells[i] <= 16'h0000;
        end else begin
            for (int i = 0; i < 16; i++) if (rf_WriteReg[i]) cells[i] <= rf_D;
        end
    end

    // Undriven bitlines read as junk so a missing R0 override shows up.
    always_comb begin
        logic [15:0] a1, a2;
        a1 = 16'h0000;
        a2 = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (rf_ReadEnable1[i]) a1 = a1 | cells[i];
            if (rf_ReadEnable2[i]) a2 = a2 | cells[i];
        end
        rf_Bitline1 = (rf_ReadEnable1 == 16'h0000) ? 16'hA5A5 : a1;
        rf_Bitline2 = (rf_ReadEnable2 == 16'h0000) ? 16'h5A5A : a2;
    end

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        logic [15:0] one;
        one = 16'h0001;
        return (idx == 4'd0) ? 16'h0000 : (one << idx);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_write(input logic [3:0] r, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_reg  = r;
        wr_data = d;
        #1;
        check("wr_strobe", {16'h0, rf_WriteReg}, {16'h0, onehot(r)});
        check("wr_data",   {16'h0, rf_D}, {16'h0, d});
        $display("write R%0d = %h strobe %h", r, d, rf_WriteReg);
        tick;
        wr_en = 1'b0;
        if (r != 4'd0) ref_rf[r] = d;
    endtask

    // One full read transaction from IDLE, optionally with a write in DRIVE.
    task automatic do_read(input logic [3:0] s1, input logic [3:0] s2,
                           input logic wr_in_drive, input logic [3:0] wreg,
                           input logic [15:0] wdata);
        logic [15:0] e1, e2;
        req_valid = 1'b1;
        req_src1  = s1;
        req_src2  = s2;
        #1;
        check("req_ready_idle", {31'h0, req_ready}, 32'h1);
        tick;
        req_valid = 1'b0;
        check("ren1", {16'h0, rf_ReadEnable1}, {16'h0, onehot(s1)});
        check("ren2", {16'h0, rf_ReadEnable2}, {16'h0, onehot(s2)});
        check("rsp_valid_drive", {31'h0, rsp_valid}, 32'h0);
        e1 = ref_rf[s1];
        e2 = ref_rf[s2];
        if (wr_in_drive) begin
            wr_en   = 1'b1;
            wr_reg  = wreg;
            wr_data = wdata;
`ifdef RF_ACCESS_BYPASS_EN
            if (wreg != 4'd0 && wreg == s1) e1 = wdata;
            if (wreg != 4'd0 && wreg == s2) e2 = wdata;
`endif
        end
        tick;
        wr_en = 1'b0;
        if (wr_in_drive && wreg != 4'd0) ref_rf[wreg] = wdata;
        check("rsp_valid_hold", {31'h0, rsp_valid}, 32'h1);
        check("rsp_data1", {16'h0, rsp_data1}, {16'h0, e1});
        check("rsp_data2", {16'h0, rsp_data2}, {16'h0, e2});
        $display("read R%0d,R%0d wr=%0d(R%0d=%h) -> %h %h (exp %h %h)",
                 s1, s2, wr_in_drive, wreg, wdata, rsp_data1, rsp_data2, e1, e2);
        tick;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_rf[i] = 16'h0000;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_src1  = 4'd0;
        req_src2  = 4'd0;
        rsp_ready = 1'b1;
        wr_en     = 1'b0;
        wr_reg    = 4'd0;
        wr_data   = 16'h0000;
        tick;
        tick;
        // Reset state
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_data1", {16'h0, rsp_data1}, 32'h0);
        check("rst_data2", {16'h0, rsp_data2}, 32'h0);
        check("rst_ren1", {16'h0, rf_ReadEnable1}, 32'h0);
        check("rst_ren2", {16'h0, rf_ReadEnable2}, 32'h0);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_wstrobe", {16'h0, rf_WriteReg}, 32'h0);
        rst = 1'b0;
        tick;

        // Preload
        do_write(4'd3, 16'h1234);
        do_write(4'd7, 16'hBEEF);
        do_write(4'd5, 16'h00FF);
        do_write(4'd4, 16'h1111);
        do_write(4'd1, 16'hAAAA);
        do_write(4'd2, 16'h5555);

        do_read(4'd3, 4'd7, 1'b0, 4'd0, 16'h0);
        do_read(4'd0, 4'd5, 1'b0, 4'd0, 16'h0);

        // Write to R0 is dropped
        do_write(4'd0, 16'hFFFF);
        do_read(4'd0, 4'd0, 1'b0, 4'd0, 16'h0);
        do_read(4'd5, 4'd5, 1'b0, 4'd0, 16'h0);

        // Response stall, then back-to-back request
        req_valid = 1'b1;
        req_src1  = 4'd1;
        req_src2  = 4'd2;
        tick;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("stall_ren1", {16'h0, rf_ReadEnable1}, {16'h0, onehot(4'd1)});
        tick;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("stall_valid", {31'h0, rsp_valid}, 32'h1);
            check("stall_data1", {16'h0, rsp_data1}, {16'h0, ref_rf[1]});
            check("stall_data2", {16'h0, rsp_data2}, {16'h0, ref_rf[2]});
            check("stall_req_ready", {31'h0, req_ready}, 32'h0);
            $display("stall cycle %0d: valid=%0d data %h %h", i, rsp_valid, rsp_data1, rsp_data2);
            tick;
        end
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_src1  = 4'd3;
        req_src2  = 4'd4;
        #1;
        check("b2b_req_ready", {31'h0, req_ready}, 32'h1);
        tick;
        req_valid = 1'b0;
        check("b2b_ren1", {16'h0, rf_ReadEnable1}, {16'h0, onehot(4'd3)});
        check("b2b_ren2", {16'h0, rf_ReadEnable2}, {16'h0, onehot(4'd4)});
        check("b2b_valid_drop", {31'h0, rsp_valid}, 32'h0);
        tick;
        check("b2b_data1", {16'h0, rsp_data1}, {16'h0, ref_rf[3]});
        check("b2b_data2", {16'h0, rsp_data2}, {16'h0, ref_rf[4]});
        $display("back-to-back read R3,R4 -> %h %h", rsp_data1, rsp_data2);
        tick;

        // Write to R4 while it is being read
        do_read(4'd4, 4'd7, 1'b1, 4'd4, 16'h2222);
        do_read(4'd4, 4'd0, 1'b0, 4'd0, 16'h0);

        // Reset in the middle of DRIVE
        req_valid = 1'b1;
        req_src1  = 4'd5;
        req_src2  = 4'd7;
        tick;
        req_valid = 1'b0;
        check("mid_ren1", {16'h0, rf_ReadEnable1}, {16'h0, onehot(4'd5)});
        rst = 1'b1;
        #1;
        check("mid_rst_ren1", {16'h0, rf_ReadEnable1}, 32'h0);
        check("mid_rst_ren2", {16'h0, rf_ReadEnable2}, 32'h0);
        check("mid_rst_valid", {31'h0, rsp_valid}, 32'h0);
        $display("reset in DRIVE: ren %h %h valid %0d", rf_ReadEnable1, rf_ReadEnable2, rsp_valid);
        tick;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) ref_rf[i] = 16'h0000;
        tick;
        check("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("post_rst_valid", {31'h0, rsp_valid}, 32'h0);
        check("post_rst_data1", {16'h0, rsp_data1}, 32'h0);

        // Randomised traffic
        for (int n = 0; n < 60; n++) begin
            logic [3:0]  a, b, w;
            logic [15:0] d;
            a = 4'($urandom_range(0, 15));
            b = ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15));
            w = ($urandom_range(0, 1) == 0) ? a : 4'($urandom_range(0, 15));
            d = 16'($urandom);
            if ($urandom_range(0, 2) == 0) do_write(w, d);
            else do_read(a, b, 1'($urandom_range(0, 1)), w, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
